// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one shift per clock).
// Latency BIN_W+1 edges after an accepted start (1 edge for invalid digits); start ignored unless ready.
module bcd_to_binary_seq #(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   logic [BW-1:0]     bcd_reg;
   logic [BIN_W-1:0]  bin_reg;
   logic [CW-1:0]     cnt;
   logic              bad_reg;

   logic [BW+BIN_W-1:0] sh;
   logic [BW-1:0]       bcd_sh;
   logic [BW-1:0]       bcd_nxt;
   logic                in_bad;

   always_comb begin
      sh      = {bcd_reg, bin_reg} >> 1;
      bcd_sh  = sh[BW+BIN_W-1:BIN_W];
      bcd_nxt = bcd_sh;
      // a digit that received a carried-in 1 in its MSB is worth 8 here but should be 5
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_sh[4*i+3])
            bcd_nxt[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9)
            in_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         bin_out <= '0;
         err     <= 1'b0;
         bcd_reg <= '0;
         bin_reg <= '0;
         cnt     <= '0;
         bad_reg <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_reg <= bcd_in;
                  bin_reg <= '0;
                  cnt     <= '0;
                  bad_reg <= in_bad;
                  ready   <= 1'b0;
                  if (in_bad) begin
                     state <= DONE;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               bcd_reg <= bcd_nxt;
               bin_reg <= sh[BIN_W-1:0];
               cnt     <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               done    <= 1'b1;
               bin_out <= bad_reg ? '0 : bin_reg;
               err     <= bad_reg;
               ready   <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: timing/value model plus directed literal checks and random traffic.
module tb_bcd_to_binary_seq;

   localparam int D  = 2;
   localparam int W  = 7;
   localparam int D2 = 3;
   localparam int W2 = 10;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [4*D-1:0] bcd;
   logic ready, busy, done, err;
   logic [W-1:0] bin_out;

   logic start2;
   logic [4*D2-1:0] bcd2;
   logic ready2, busy2, done2, err2;
   logic [W2-1:0] bin_out2;

   int checks = 0;
   int passed = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   bcd_to_binary_seq #(.DIGITS(D), .BIN_W(W)) dut (
      .clk(clk), .reset(rst), .start(start), .bcd_in(bcd),
      .ready(ready), .busy(busy), .done(done), .bin_out(bin_out), .err(err)
   );

   bcd_to_binary_seq #(.DIGITS(D2), .BIN_W(W2)) dut_wide (
      .clk(clk), .reset(rst), .start(start2), .bcd_in(bcd2),
      .ready(ready2), .busy(busy2), .done(done2), .bin_out(bin_out2), .err(err2)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int dec_val(input logic [4*D-1:0] v);
      int r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic bit dec_bad(input logic [4*D-1:0] v);
      bit b = 1'b0;
      for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
      return b;
   endfunction

   function automatic logic [4*D-1:0] gen();
      logic [4*D-1:0] v;
      for (int i = 0; i < D; i++)
         v[4*i +: 4] = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      return v;
   endfunction

   // model: edges remaining until the done pulse, plus the result it will publish
   int m_left = 0;
   int m_pend_val = 0;
   bit m_pend_err = 1'b0;
   int exp_bin = 0;
   bit exp_err = 1'b0;
   bit exp_done = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; exp_bin = 0; exp_err = 1'b0; exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               exp_done = 1'b1;
               exp_bin  = m_pend_err ? 0 : m_pend_val;
               exp_err  = m_pend_err;
            end
         end else if (start) begin
            m_pend_err = dec_bad(bcd);
            m_pend_val = dec_val(bcd);
            m_left     = m_pend_err ? 1 : W + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("ready", int'(ready), int'(m_left == 0));
         chk("busy", int'(busy), int'(m_left > 1));
         chk("done", int'(done), int'(exp_done));
         chk("bin_out", int'(bin_out), exp_bin);
         chk("err", int'(err), int'(exp_err));
      end
   end

   task automatic run_one(input logic [4*D-1:0] v, input int ev, input int ee, input int elat);
      int lat;
      @(negedge clk); start = 1'b1; bcd = v;
      @(negedge clk); start = 1'b0; bcd = 8'($urandom);
      lat = 1;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      chk("latency", lat, elat);
      chk("res_bin", int'(bin_out), ev);
      chk("res_err", int'(err), ee);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("ready_after", int'(ready), 1);
   endtask

   task automatic run_wide(input logic [4*D2-1:0] v, input int ev);
      int lat;
      @(negedge clk); start2 = 1'b1; bcd2 = v;
      @(negedge clk); start2 = 1'b0; bcd2 = '0;
      chk("wide_busy", int'(busy2), 1);
      lat = 1;
      while (!done2 && lat < 40) begin @(negedge clk); lat++; end
      chk("wide_latency", lat, W2 + 2);
      chk("wide_bin", int'(bin_out2), ev);
      chk("wide_err", int'(err2), 0);
      @(negedge clk);
      chk("wide_ready", int'(ready2), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone, first, second, idx;
      rst = 1'b1; start = 1'b0; bcd = '0; start2 = 1'b0; bcd2 = '0;
      #23;
      chk("rst_ready", int'(ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_bin", int'(bin_out), 0);
      chk("rst_err", int'(err), 0);
      @(negedge clk); rst = 1'b0; chk_en = 1'b1;

      run_one(8'h45, 45, 0, W + 2);
      run_one(8'h00, 0, 0, W + 2);
      run_one(8'h09, 9, 0, W + 2);
      run_one(8'h10, 10, 0, W + 2);
      run_one(8'h99, 99, 0, W + 2);
      for (int t = 0; t < 10; t++)
         for (int o = 0; o < 10; o++)
            run_one({4'(t), 4'(o)}, t * 10 + o, 0, W + 2);

      run_one(8'h4A, 0, 1, 2);
      run_one(8'hF0, 0, 1, 2);
      run_one(8'h12, 12, 0, W + 2);

      // starts during a conversion must be dropped
      @(negedge clk); start = 1'b1; bcd = 8'h37;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; bcd = 8'h88;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; bcd = 8'h88;
      @(negedge clk); start = 1'b0;
      ndone = 0;
      repeat (12) begin @(negedge clk); if (done) ndone++; end
      chk("ignored_dones", ndone, 1);
      chk("ignored_bin", int'(bin_out), 37);

      // asynchronous reset in the middle of a conversion
      @(negedge clk); start = 1'b1; bcd = 8'h64;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("abort_ready", int'(ready), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_bin", int'(bin_out), 0);
      chk("abort_err", int'(err), 0);
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      repeat (12) begin @(negedge clk); if (done) ndone++; end
      chk("abort_no_done", ndone, 0);
      run_one(8'h21, 21, 0, W + 2);

      // start held high: conversions back to back
      @(negedge clk); start = 1'b1; bcd = 8'h50;
      first = -1; second = -1; ndone = 0;
      for (idx = 1; idx <= 30; idx++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first < 0) first = idx; else if (second < 0) second = idx;
            chk("b2b_bin", int'(bin_out), 50);
         end
      end
      start = 1'b0;
      chk("b2b_count", ndone, 3);
      chk("b2b_period", second - first, W + 2);
      repeat (15) @(negedge clk);

      // random traffic, model checks every cycle
      repeat (3000) begin
         @(negedge clk);
         start = ($urandom % 3 == 0);
         bcd   = gen();
      end
      start = 1'b0;
      repeat (15) @(negedge clk);

      run_wide(12'h999, 999);
      run_wide(12'h123, 123);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
